// File: rtl/pipeline_sequencer.sv
// Pipeline stall/flush sequencer: hazard priority (mem-wait > redirect > load-use), boot/halt/dflush FSM, perf counters, watchdog.
// Controls are combinational from state and hazards (0 cycles); counters and watchdog update one cycle later; stalls hold every stage.
module pipeline_sequencer #(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             lu_hazard,
    input  logic             redirect_EX,
    input  logic             halt_MEM,
    input  logic             dflush_done,
    output logic             pipeline_ctrl,
    output logic             Write_IF_ID,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             pc_en,
    output logic             imemREN,
    output logic             dflush_req,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             wdog_err
);
    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_t;

    localparam int              WD_W   = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_LIMIT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    logic run;
    logic adv;
    logic stall;

    assign run   = (state_q == RUN);
    assign adv   = run && ihit && (!dmem_req || dhit);
    assign stall = run && !adv;

    // Redirect outranks load-use: the bubble is subsumed by the flush and PC takes the target.
    assign pipeline_ctrl = adv;
    assign Write_IF_ID   = run && lu_hazard && !redirect_EX;
    assign flush_IF_ID   = adv && redirect_EX;
    assign flush_ID_EX   = adv && (redirect_EX || lu_hazard);
    assign pc_en         = adv && (redirect_EX || !lu_hazard);
    assign imemREN       = run;
    assign dflush_req    = (state_q == DRAIN);
    assign halt          = (state_q == HALT);
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign wdog_err      = wdog_err_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (adv && halt_MEM) state_d = DRAIN;
            DRAIN:   if (dflush_done) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stall)
            stall_cnt_d = sat_inc(stall_cnt_q);
        if (adv && lu_hazard && !redirect_EX)
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        if (adv && redirect_EX)
            flush_cnt_d = sat_inc(flush_cnt_q);
    end

    // Counter clears on any advance or outside RUN; it parks at the limit once reached.
    always_comb begin
        wdog_cnt_d = '0;
        wdog_err_d = wdog_err_q;
        if ((WDOG_LIMIT != 0) && stall) begin
            wdog_cnt_d = (wdog_cnt_q == WD_LIM) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
            if (wdog_cnt_q == WD_LIM - 1'b1)
                wdog_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= BOOT;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            wdog_cnt_q   <= '0;
            wdog_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_err_q   <= wdog_err_d;
        end
    end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random traffic against a per-cycle action model.
module tb_pipeline_sequencer;
    localparam int CNT_W      = 16;
    localparam int WDOG_LIMIT = 8;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, dmem_req = 1'b0, lu_hazard = 1'b0;
    logic redirect_EX = 1'b0, halt_MEM = 1'b0, dflush_done = 1'b0;
    logic pipeline_ctrl, Write_IF_ID, flush_IF_ID, flush_ID_EX, pc_en, imemREN;
    logic dflush_req, halt, wdog_err;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

    always #5 CLK = ~CLK;

    pipeline_sequencer #(.CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .lu_hazard(lu_hazard), .redirect_EX(redirect_EX), .halt_MEM(halt_MEM),
        .dflush_done(dflush_done), .pipeline_ctrl(pipeline_ctrl), .Write_IF_ID(Write_IF_ID),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .pc_en(pc_en), .imemREN(imemREN),
        .dflush_req(dflush_req), .halt(halt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt), .wdog_err(wdog_err)
    );

    logic [56:0] obs;
    assign obs = {pipeline_ctrl, Write_IF_ID, flush_IF_ID, flush_ID_EX, pc_en, imemREN,
                  dflush_req, halt, wdog_err, stall_cnt, bubble_cnt, flush_cnt};

    int tests = 0;
    int fails = 0;

    // Reference model: what the pipeline does this cycle, decided from the hazard priority.
    typedef enum int {M_BOOT, M_RUN, M_DRAIN, M_HALT} mstate_t;
    typedef enum int {A_IDLE, A_FREEZE, A_REDIR, A_BUBBLE, A_GO} act_t;
    mstate_t m_state = M_BOOT;
    int m_stall = 0, m_bub = 0, m_fl = 0, m_wd = 0;
    bit m_err = 1'b0;

    function automatic act_t action();
        if (m_state != M_RUN) return A_IDLE;
        if (!ihit || (dmem_req && !dhit)) return A_FREEZE;
        if (redirect_EX) return A_REDIR;
        if (lu_hazard) return A_BUBBLE;
        return A_GO;
    endfunction

    function automatic logic [56:0] expv();
        act_t a = action();
        logic moves = (a == A_REDIR) || (a == A_BUBBLE) || (a == A_GO);
        logic hold  = (m_state == M_RUN) && lu_hazard && !redirect_EX;
        return {moves, hold, a == A_REDIR, (a == A_REDIR) || (a == A_BUBBLE),
                (a == A_REDIR) || (a == A_GO), m_state == M_RUN, m_state == M_DRAIN,
                m_state == M_HALT, m_err, m_stall[CNT_W-1:0], m_bub[CNT_W-1:0], m_fl[CNT_W-1:0]};
    endfunction

    task automatic model_reset();
        m_state = M_BOOT; m_stall = 0; m_bub = 0; m_fl = 0; m_wd = 0; m_err = 1'b0;
    endtask

    task automatic model_step();
        act_t a = action();
        if (!nRST) return;
        if (a == A_FREEZE) begin
            if (m_stall < CMAX) m_stall++;
            if (m_wd < WDOG_LIMIT) m_wd++;
            if (WDOG_LIMIT != 0 && m_wd == WDOG_LIMIT) m_err = 1'b1;
        end else begin
            m_wd = 0;
        end
        if (a == A_BUBBLE && m_bub < CMAX) m_bub++;
        if (a == A_REDIR && m_fl < CMAX) m_fl++;
        case (m_state)
            M_BOOT:  m_state = M_RUN;
            M_RUN:   if (a != A_FREEZE && halt_MEM) m_state = M_DRAIN;
            M_DRAIN: if (dflush_done) m_state = M_HALT;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic ih, input logic dr, input logic dh, input logic lu,
                          input logic rd, input logic hm, input logic dd);
        ihit = ih; dmem_req = dr; dhit = dh; lu_hazard = lu;
        redirect_EX = rd; halt_MEM = hm; dflush_done = dd;
    endtask

    task automatic assert_reset();
        nRST = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        assert_reset();
        tests++; if (obs !== '0) begin fails++; $display("FAIL reset_low: got %h exp 0", obs); end
        release_reset();
        tests++; if (obs !== expv()) begin fails++; $display("FAIL boot_cycle: got %h exp %h", obs, expv()); end
        tests++; if ({pipeline_ctrl, imemREN} !== 2'b00) begin fails++; $display("FAIL boot_ctrl: got %b exp 00", {pipeline_ctrl, imemREN}); end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++; if (obs !== expv()) begin fails++; $display("FAIL run_c%0d: got %h exp %h", i, obs, expv()); end
            tests++; if ({pipeline_ctrl, pc_en, flush_IF_ID, flush_ID_EX} !== 4'b1100) begin fails++; $display("FAIL run_ctrl_c%0d: got %b exp 1100", i, {pipeline_ctrl, pc_en, flush_IF_ID, flush_ID_EX}); end
            tick();
        end
    endtask

    task automatic test_stalls();
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++; if (obs !== expv()) begin fails++; $display("FAIL istall_c%0d: got %h exp %h", i, obs, expv()); end
            tick();
        end
        ihit = 1'b1;
        @(negedge CLK);
        tests++; if (stall_cnt !== 16'd3 || pipeline_ctrl !== 1'b1) begin fails++; $display("FAIL istall_cnt: got %0d/%b exp 3/1", stall_cnt, pipeline_ctrl); end
        tick();
        set_in(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            tests++; if (obs !== expv()) begin fails++; $display("FAIL dstall_c%0d: got %h exp %h", i, obs, expv()); end
            tick();
        end
        dhit = 1'b1;
        @(negedge CLK);
        tests++; if (stall_cnt !== 16'd5 || pipeline_ctrl !== 1'b1) begin fails++; $display("FAIL dstall_cnt: got %0d/%b exp 5/1", stall_cnt, pipeline_ctrl); end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 1, 0, 0, 0);
        @(negedge CLK);
        tests++; if ({Write_IF_ID, pc_en, flush_ID_EX, flush_IF_ID} !== 4'b1010) begin fails++; $display("FAIL lu_ctrl: got %b exp 1010", {Write_IF_ID, pc_en, flush_ID_EX, flush_IF_ID}); end
        tick();
        lu_hazard = 1'b0;
        @(negedge CLK);
        tests++; if (bubble_cnt !== 16'd1 || obs !== expv()) begin fails++; $display("FAIL lu_cnt: got %0d exp 1", bubble_cnt); end
        tick();
        set_in(1, 0, 0, 1, 1, 0, 0);
        @(negedge CLK);
        tests++; if ({flush_IF_ID, pc_en, Write_IF_ID, flush_ID_EX} !== 4'b1101) begin fails++; $display("FAIL lu_redir_ctrl: got %b exp 1101", {flush_IF_ID, pc_en, Write_IF_ID, flush_ID_EX}); end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        tests++; if (flush_cnt !== 16'd1 || bubble_cnt !== 16'd1) begin fails++; $display("FAIL lu_redir_cnt: got %0d/%0d exp 1/1", flush_cnt, bubble_cnt); end
        tick();
    endtask

    task automatic test_redirect_stalled();
        set_in(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++; if ({flush_IF_ID, flush_ID_EX, pipeline_ctrl} !== 3'b000 || obs !== expv()) begin fails++; $display("FAIL redir_hold_c%0d: got %h exp %h", i, obs, expv()); end
            tick();
        end
        ihit = 1'b1;
        @(negedge CLK);
        tests++; if ({flush_IF_ID, flush_ID_EX, pipeline_ctrl} !== 3'b111) begin fails++; $display("FAIL redir_go: got %b exp 111", {flush_IF_ID, flush_ID_EX, pipeline_ctrl}); end
        tick();
        redirect_EX = 1'b0;
        @(negedge CLK);
        tests++; if (obs !== expv()) begin fails++; $display("FAIL redir_after: got %h exp %h", obs, expv()); end
        tick();
    endtask

    task automatic test_halt();
        set_in(1, 0, 0, 0, 0, 0, 0);
        assert_reset(); release_reset(); tick();
        halt_MEM = 1'b1;
        @(negedge CLK);
        tests++; if (pipeline_ctrl !== 1'b1 || obs !== expv()) begin fails++; $display("FAIL halt_commit: got %h exp %h", obs, expv()); end
        tick();
        halt_MEM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dflush_done = (i == 3);
            @(negedge CLK);
            tests++; if ({dflush_req, pipeline_ctrl, halt} !== 3'b100 || obs !== expv()) begin fails++; $display("FAIL drain_c%0d: got %h exp %h", i, obs, expv()); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge CLK);
            tests++; if (halt !== 1'b1 || obs !== expv()) begin fails++; $display("FAIL halted_c%0d: got %h exp %h", i, obs, expv()); end
            tick();
        end
        set_in(1, 0, 0, 0, 0, 0, 0);
        assert_reset(); release_reset(); tick();
        halt_MEM = 1'b1;
        tick();
        halt_MEM = 1'b0;
        tick(); tick();
        assert_reset();
        tests++; if (obs !== '0) begin fails++; $display("FAIL drain_reset: got %h exp 0", obs); end
        release_reset();
        tests++; if (obs !== '0) begin fails++; $display("FAIL drain_reboot: got %h exp 0", obs); end
        tick();
    endtask

    task automatic test_watchdog();
        set_in(1, 0, 0, 0, 0, 0, 0);
        assert_reset(); release_reset(); tick();
        ihit = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            tests++; if (wdog_err !== (i >= WDOG_LIMIT) || obs !== expv()) begin fails++; $display("FAIL wdog_c%0d: got %b exp %b", i, wdog_err, i >= WDOG_LIMIT); end
            tick();
        end
        ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++; if (wdog_err !== 1'b1 || obs !== expv()) begin fails++; $display("FAIL wdog_sticky_c%0d: got %h exp %h", i, obs, expv()); end
            tick();
        end
    endtask

    task automatic test_random();
        set_in(1, 0, 0, 0, 0, 0, 0);
        assert_reset(); release_reset(); tick();
        for (int i = 0; i < 600; i++) begin
            if ((m_state == M_HALT && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) begin
                assert_reset();
                tests++; if (obs !== '0) begin fails++; $display("FAIL rnd_reset_%0d: got %h exp 0", i, obs); end
                release_reset();
                tick();
            end else begin
                set_in($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
                @(negedge CLK);
                tests++; if (obs !== expv()) begin fails++; $display("FAIL rnd_%0d: got %h exp %h", i, obs, expv()); end
                tick();
            end
        end
    endtask

    task automatic test_saturation();
        set_in(1, 0, 0, 0, 0, 0, 0);
        assert_reset(); release_reset(); tick();
        ihit = 1'b0;
        repeat (CMAX + 5) tick();
        @(negedge CLK);
        tests++; if (stall_cnt !== 16'hFFFF || obs !== expv()) begin fails++; $display("FAIL stall_sat: got %h exp ffff", stall_cnt); end
        tick();
        ihit = 1'b1;
        @(negedge CLK);
        tests++; if (obs !== expv()) begin fails++; $display("FAIL sat_resume: got %h exp %h", obs, expv()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stalls();
        test_load_use();
        test_redirect_stalled();
        test_halt();
        test_watchdog();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
